// File: rtl/xbar_rr_arbiter.sv
// M-master x S-slave request/ack/response crossbar with one arbitration FSM per slave.
// Each slave picks among its requesters (round-robin or fixed priority) and forwards one access at a time.
module xbar_rr_arbiter #(
    parameter int M        = 4,
    parameter int S        = 4,
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int ARB_MODE = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [M-1:0]                 m_req,
    input  logic [M-1:0]                 m_cmd,
    input  logic [M*AW-1:0]              m_addr,
    input  logic [M*DW-1:0]              m_wdata,
    output logic [M-1:0]                 m_ack,
    output logic [M-1:0]                 m_resp,
    output logic [M*DW-1:0]              m_rdata,
    output logic [S-1:0]                 s_req,
    output logic [S-1:0]                 s_cmd,
    output logic [S*(AW-$clog2(S))-1:0]  s_addr,
    output logic [S*DW-1:0]              s_wdata,
    input  logic [S-1:0]                 s_ack,
    input  logic [S-1:0]                 s_resp,
    input  logic [S*DW-1:0]              s_rdata
);

    localparam int SW  = $clog2(S);
    localparam int MW  = (M > 1) ? $clog2(M) : 1;
    localparam int SAW = AW - SW;

    typedef enum logic [1:0] {IDLE, ADDR, RESP} state_t;

    state_t        state_q [S];
    state_t        state_d [S];
    logic [MW-1:0] owner_q [S];
    logic [MW-1:0] owner_d [S];
    logic [MW-1:0] ptr_q   [S];
    logic [MW-1:0] ptr_d   [S];
    logic [S-1:0]  resp_fire;
    logic [SW-1:0] m_sel   [M];

    function automatic logic [MW-1:0] next_ptr(input logic [MW-1:0] cur);
        if (M == 1 || int'(cur) >= M - 1) return '0;
        return cur + 1'b1;
    endfunction

    always_comb begin
        for (int i = 0; i < M; i++) begin
            m_sel[i] = m_addr[i*AW + AW - 1 -: SW];
        end
    end

    // Arbitration and transaction tracking; resp_fire marks a response that reaches the owner this cycle.
    always_comb begin : next_state
        int   idx;
        logic found;
        idx       = 0;
        found     = 1'b0;
        resp_fire = '0;
        for (int s = 0; s < S; s++) begin
            state_d[s] = state_q[s];
            owner_d[s] = owner_q[s];
            ptr_d[s]   = ptr_q[s];
            found      = 1'b0;
            case (state_q[s])
                IDLE: begin
                    for (int k = 0; k < M; k++) begin
                        idx = (ARB_MODE == 0) ? int'(ptr_q[s]) + k : k;
                        if (idx >= M) idx = idx - M;
                        if (!found && m_req[idx] && m_sel[idx] == SW'(s)) begin
                            found      = 1'b1;
                            owner_d[s] = MW'(idx);
                        end
                    end
                    if (found) state_d[s] = ADDR;
                end
                ADDR: begin
                    if (s_ack[s]) begin
                        if (s_resp[s]) begin
                            resp_fire[s] = 1'b1;
                            state_d[s]   = IDLE;
                            ptr_d[s]     = next_ptr(owner_q[s]);
                        end else begin
                            state_d[s] = RESP;
                        end
                    end
                end
                RESP: begin
                    if (s_resp[s]) begin
                        resp_fire[s] = 1'b1;
                        state_d[s]   = IDLE;
                        ptr_d[s]     = next_ptr(owner_q[s]);
                    end
                end
                default: state_d[s] = IDLE;
            endcase
        end
    end

    // Route the owning master onto its slave and the slave's ack/response back to that master.
    always_comb begin
        m_ack   = '0;
        m_resp  = '0;
        m_rdata = '0;
        s_req   = '0;
        s_cmd   = '0;
        s_addr  = '0;
        s_wdata = '0;
        for (int s = 0; s < S; s++) begin
            if (state_q[s] == ADDR) begin
                s_req[s]               = 1'b1;
                s_cmd[s]               = m_cmd[owner_q[s]];
                s_addr[s*SAW +: SAW]   = m_addr[int'(owner_q[s])*AW +: SAW];
                s_wdata[s*DW +: DW]    = m_wdata[int'(owner_q[s])*DW +: DW];
                m_ack[owner_q[s]]      = m_ack[owner_q[s]] | s_ack[s];
            end
            if (resp_fire[s]) begin
                m_resp[owner_q[s]]                  = 1'b1;
                m_rdata[int'(owner_q[s])*DW +: DW]  = s_rdata[s*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s < S; s++) begin
            if (!rst_n) begin
                state_q[s] <= IDLE;
                owner_q[s] <= '0;
                ptr_q[s]   <= '0;
            end else begin
                state_q[s] <= state_d[s];
                owner_q[s] <= owner_d[s];
                ptr_q[s]   <= ptr_d[s];
            end
        end
    end

endmodule

// File: tb/tb_xbar_rr_arbiter.sv
// Directed bench for xbar_rr_arbiter: one round-robin and one fixed-priority instance share all inputs.
module tb_xbar_rr_arbiter;

    localparam int M   = 4;
    localparam int S   = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SAW = 30;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [M-1:0]    m_req, m_cmd;
    logic [M*AW-1:0] m_addr;
    logic [M*DW-1:0] m_wdata;
    logic [S-1:0]    s_ack, s_resp;
    logic [S*DW-1:0] s_rdata;

    logic [M-1:0]     m_ack, m_resp;
    logic [M*DW-1:0]  m_rdata;
    logic [S-1:0]     s_req, s_cmd;
    logic [S*SAW-1:0] s_addr;
    logic [S*DW-1:0]  s_wdata;

    logic [M-1:0]     fp_m_ack, fp_m_resp;
    logic [M*DW-1:0]  fp_m_rdata;
    logic [S-1:0]     fp_s_req, fp_s_cmd;
    logic [S*SAW-1:0] fp_s_addr;
    logic [S*DW-1:0]  fp_s_wdata;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    xbar_rr_arbiter #(.M(M), .S(S), .AW(AW), .DW(DW), .ARB_MODE(0)) dut_rr (
        .clk(clk), .rst_n(rst_n), .m_req(m_req), .m_cmd(m_cmd), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_ack(m_ack), .m_resp(m_resp), .m_rdata(m_rdata),
        .s_req(s_req), .s_cmd(s_cmd), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_ack(s_ack), .s_resp(s_resp), .s_rdata(s_rdata)
    );

    xbar_rr_arbiter #(.M(M), .S(S), .AW(AW), .DW(DW), .ARB_MODE(1)) dut_fp (
        .clk(clk), .rst_n(rst_n), .m_req(m_req), .m_cmd(m_cmd), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_ack(fp_m_ack), .m_resp(fp_m_resp), .m_rdata(fp_m_rdata),
        .s_req(fp_s_req), .s_cmd(fp_s_cmd), .s_addr(fp_s_addr), .s_wdata(fp_s_wdata),
        .s_ack(s_ack), .s_resp(s_resp), .s_rdata(s_rdata)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_master(input int i, input logic req, input logic cmd,
                              input logic [31:0] addr, input logic [31:0] wdata);
        m_req[i]            = req;
        m_cmd[i]            = cmd;
        m_addr[i*AW +: AW]  = addr;
        m_wdata[i*DW +: DW] = wdata;
    endtask

    task automatic reset_dut();
        rst_n   = 1'b0;
        m_req   = '0;
        m_cmd   = '0;
        m_addr  = '0;
        m_wdata = '0;
        s_ack   = '0;
        s_resp  = '0;
        s_rdata = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_dut();
        #1;
        n_checks++; if (m_ack   !== 4'b0) $display("[TB] FAIL reset_m_ack got %b expected 0", m_ack);     else n_pass++;
        n_checks++; if (m_resp  !== 4'b0) $display("[TB] FAIL reset_m_resp got %b expected 0", m_resp);   else n_pass++;
        n_checks++; if (m_rdata !== '0)   $display("[TB] FAIL reset_m_rdata got %h expected 0", m_rdata); else n_pass++;
        n_checks++; if (s_req   !== 4'b0) $display("[TB] FAIL reset_s_req got %b expected 0", s_req);     else n_pass++;
        n_checks++; if (s_addr  !== '0)   $display("[TB] FAIL reset_s_addr got %h expected 0", s_addr);   else n_pass++;
        n_checks++; if (s_wdata !== '0)   $display("[TB] FAIL reset_s_wdata got %h expected 0", s_wdata); else n_pass++;
    endtask

    task automatic test_single_read();
        reset_dut();
        set_master(0, 1'b1, 1'b0, 32'h4000_0010, 32'h0);
        #1;
        n_checks++; if (s_req !== 4'b0000) $display("[TB] FAIL rd_s_req_early got %b expected 0000", s_req); else n_pass++;
        step();
        #1;
        n_checks++; if (s_req !== 4'b0010) $display("[TB] FAIL rd_s_req got %b expected 0010", s_req); else n_pass++;
        n_checks++; if (s_addr[1*SAW +: SAW] !== 30'h10) $display("[TB] FAIL rd_s_addr got %h expected 10", s_addr[1*SAW +: SAW]); else n_pass++;
        n_checks++; if (m_ack !== 4'b0000) $display("[TB] FAIL rd_ack_before_sack got %b expected 0000", m_ack); else n_pass++;
        s_ack = 4'b0010;
        #1;
        n_checks++; if (m_ack !== 4'b0001) $display("[TB] FAIL rd_m_ack got %b expected 0001", m_ack); else n_pass++;
        step();
        m_req[0] = 1'b0;
        s_ack    = '0;
        #1;
        n_checks++; if (s_req !== 4'b0000) $display("[TB] FAIL rd_s_req_in_resp got %b expected 0000", s_req); else n_pass++;
        n_checks++; if (m_resp !== 4'b0000) $display("[TB] FAIL rd_m_resp_early got %b expected 0000", m_resp); else n_pass++;
        step();
        s_resp              = 4'b0010;
        s_rdata[1*DW +: DW] = 32'hDEAD_BEEF;
        #1;
        n_checks++; if (m_resp !== 4'b0001) $display("[TB] FAIL rd_m_resp got %b expected 0001", m_resp); else n_pass++;
        n_checks++; if (m_rdata[0 +: DW] !== 32'hDEAD_BEEF) $display("[TB] FAIL rd_m_rdata got %h expected deadbeef", m_rdata[0 +: DW]); else n_pass++;
        n_checks++; if (m_rdata[DW +: 3*DW] !== '0) $display("[TB] FAIL rd_other_rdata got %h expected 0", m_rdata[DW +: 3*DW]); else n_pass++;
        step();
        s_resp  = '0;
        s_rdata = '0;
        #1;
        n_checks++; if (m_resp !== 4'b0000) $display("[TB] FAIL rd_m_resp_after got %b expected 0000", m_resp); else n_pass++;
        n_checks++; if (m_rdata !== '0) $display("[TB] FAIL rd_m_rdata_after got %h expected 0", m_rdata); else n_pass++;
    endtask

    task automatic test_round_robin();
        int g;
        int exp_m;
        reset_dut();
        for (int i = 0; i < M; i++) set_master(i, 1'b1, 1'b1, 32'h8000_0000 | (i * 4), 32'hA000_0000 + i);
        s_ack  = 4'b0100;
        s_resp = 4'b0100;
        g = 0;
        for (int c = 0; c < 30 && g < 5; c++) begin
            #1;
            if (m_ack != 4'b0) begin
                exp_m = g % 4;
                n_checks++; if (m_ack !== 4'(1 << exp_m)) $display("[TB] FAIL rr_grant%0d got %b expected %b", g, m_ack, 4'(1 << exp_m)); else n_pass++;
                n_checks++; if (m_resp !== 4'(1 << exp_m)) $display("[TB] FAIL rr_resp%0d got %b expected %b", g, m_resp, 4'(1 << exp_m)); else n_pass++;
                n_checks++; if (s_wdata[2*DW +: DW] !== 32'hA000_0000 + exp_m) $display("[TB] FAIL rr_wdata%0d got %h expected %h", g, s_wdata[2*DW +: DW], 32'hA000_0000 + exp_m); else n_pass++;
                n_checks++; if (s_addr[2*SAW +: SAW] !== 30'(exp_m * 4)) $display("[TB] FAIL rr_addr%0d got %h expected %h", g, s_addr[2*SAW +: SAW], 30'(exp_m * 4)); else n_pass++;
                g++;
            end
            step();
        end
        n_checks++; if (g !== 5) $display("[TB] FAIL rr_grant_count got %0d expected 5", g); else n_pass++;
    endtask

    task automatic test_fixed_priority();
        int g;
        logic [3:0] exp_g;
        reset_dut();
        for (int i = 0; i < M; i++) set_master(i, 1'b1, 1'b1, 32'h8000_0000 | (i * 4), 32'hB000_0000 + i);
        s_ack  = 4'b0100;
        s_resp = 4'b0100;
        g = 0;
        for (int c = 0; c < 30 && g < 5; c++) begin
            #1;
            if (fp_m_ack != 4'b0) begin
                exp_g = (g < 3) ? 4'b0001 : 4'b0010;
                n_checks++; if (fp_m_ack !== exp_g) $display("[TB] FAIL fp_grant%0d got %b expected %b", g, fp_m_ack, exp_g); else n_pass++;
                g++;
                if (g == 3) m_req[0] = 1'b0;
            end
            step();
        end
        n_checks++; if (g !== 5) $display("[TB] FAIL fp_grant_count got %0d expected 5", g); else n_pass++;
    endtask

    task automatic test_concurrency();
        reset_dut();
        set_master(0, 1'b1, 1'b0, 32'h0000_0020, 32'h0);
        set_master(1, 1'b1, 1'b0, 32'hC000_0030, 32'h0);
        step();
        #1;
        n_checks++; if (s_req !== 4'b1001) $display("[TB] FAIL cc_s_req got %b expected 1001", s_req); else n_pass++;
        n_checks++; if (s_addr[0 +: SAW] !== 30'h20) $display("[TB] FAIL cc_addr0 got %h expected 20", s_addr[0 +: SAW]); else n_pass++;
        n_checks++; if (s_addr[3*SAW +: SAW] !== 30'h30) $display("[TB] FAIL cc_addr3 got %h expected 30", s_addr[3*SAW +: SAW]); else n_pass++;
        s_ack = 4'b0001;
        #1;
        n_checks++; if (m_ack !== 4'b0001) $display("[TB] FAIL cc_ack0 got %b expected 0001", m_ack); else n_pass++;
        step();
        m_req[0]            = 1'b0;
        s_ack               = 4'b1000;
        s_resp              = 4'b0001;
        s_rdata[0 +: DW]    = 32'h1111_0000;
        #1;
        n_checks++; if (m_ack !== 4'b0010) $display("[TB] FAIL cc_ack1 got %b expected 0010", m_ack); else n_pass++;
        n_checks++; if (m_resp !== 4'b0001) $display("[TB] FAIL cc_resp0 got %b expected 0001", m_resp); else n_pass++;
        n_checks++; if (m_rdata[0 +: DW] !== 32'h1111_0000) $display("[TB] FAIL cc_rdata0 got %h expected 11110000", m_rdata[0 +: DW]); else n_pass++;
        step();
        m_req[1]            = 1'b0;
        s_ack               = '0;
        s_resp              = 4'b1000;
        s_rdata[3*DW +: DW] = 32'h3333_0003;
        #1;
        n_checks++; if (m_resp !== 4'b0010) $display("[TB] FAIL cc_resp1 got %b expected 0010", m_resp); else n_pass++;
        n_checks++; if (m_rdata[DW +: DW] !== 32'h3333_0003) $display("[TB] FAIL cc_rdata1 got %h expected 33330003", m_rdata[DW +: DW]); else n_pass++;
        step();
        s_resp  = '0;
        s_rdata = '0;
    endtask

    task automatic test_back_to_back();
        reset_dut();
        set_master(2, 1'b1, 1'b0, 32'h4000_0000, 32'h0);
        set_master(3, 1'b1, 1'b0, 32'h4000_0008, 32'h0);
        step();
        s_ack               = 4'b0010;
        s_resp              = 4'b0010;
        s_rdata[1*DW +: DW] = 32'hCAFE_F00D;
        #1;
        n_checks++; if (m_ack !== 4'b0100) $display("[TB] FAIL bb_ack2 got %b expected 0100", m_ack); else n_pass++;
        n_checks++; if (m_resp !== 4'b0100) $display("[TB] FAIL bb_resp2 got %b expected 0100", m_resp); else n_pass++;
        n_checks++; if (m_rdata[2*DW +: DW] !== 32'hCAFE_F00D) $display("[TB] FAIL bb_rdata2 got %h expected cafef00d", m_rdata[2*DW +: DW]); else n_pass++;
        step();
        m_req[2] = 1'b0;
        #1;
        n_checks++; if (s_req !== 4'b0000) $display("[TB] FAIL bb_idle_s_req got %b expected 0000", s_req); else n_pass++;
        n_checks++; if (m_resp !== 4'b0000) $display("[TB] FAIL bb_idle_resp_ignored got %b expected 0000", m_resp); else n_pass++;
        step();
        #1;
        n_checks++; if (s_addr[1*SAW +: SAW] !== 30'h8) $display("[TB] FAIL bb_addr3 got %h expected 8", s_addr[1*SAW +: SAW]); else n_pass++;
        n_checks++; if (m_ack !== 4'b1000) $display("[TB] FAIL bb_ack3 got %b expected 1000", m_ack); else n_pass++;
        n_checks++; if (m_resp !== 4'b1000) $display("[TB] FAIL bb_resp3 got %b expected 1000", m_resp); else n_pass++;
        step();
        m_req   = '0;
        s_ack   = '0;
        s_resp  = '0;
        s_rdata = '0;
    endtask

    task automatic test_reset_mid();
        reset_dut();
        set_master(2, 1'b1, 1'b0, 32'h4000_0000, 32'h0);
        step();
        s_ack  = 4'b0010;
        s_resp = 4'b0010;
        step();
        m_req[2] = 1'b0;
        s_ack    = '0;
        s_resp   = '0;
        set_master(1, 1'b1, 1'b0, 32'h4000_0004, 32'h0);
        step();
        s_ack = 4'b0010;
        #1;
        n_checks++; if (m_ack !== 4'b0010) $display("[TB] FAIL rm_ack1 got %b expected 0010", m_ack); else n_pass++;
        step();
        m_req[1] = 1'b0;
        s_ack    = '0;
        rst_n    = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        n_checks++; if (m_ack !== 4'b0 || m_resp !== 4'b0) $display("[TB] FAIL rm_master_out got ack=%b resp=%b expected 0", m_ack, m_resp); else n_pass++;
        n_checks++; if (s_req !== 4'b0 || s_addr !== '0) $display("[TB] FAIL rm_slave_out got req=%b addr=%h expected 0", s_req, s_addr); else n_pass++;
        s_resp              = 4'b0010;
        s_rdata[1*DW +: DW] = 32'h5555_AAAA;
        #1;
        n_checks++; if (m_resp !== 4'b0000) $display("[TB] FAIL rm_late_resp got %b expected 0000", m_resp); else n_pass++;
        n_checks++; if (m_rdata !== '0) $display("[TB] FAIL rm_late_rdata got %h expected 0", m_rdata); else n_pass++;
        step();
        s_resp  = '0;
        s_rdata = '0;
        set_master(1, 1'b1, 1'b0, 32'h4000_0004, 32'h0);
        set_master(3, 1'b1, 1'b0, 32'h4000_000C, 32'h0);
        step();
        s_ack = 4'b0010;
        #1;
        n_checks++; if (s_addr[1*SAW +: SAW] !== 30'h4) $display("[TB] FAIL rm_post_addr got %h expected 4", s_addr[1*SAW +: SAW]); else n_pass++;
        n_checks++; if (m_ack !== 4'b0010) $display("[TB] FAIL rm_post_grant got %b expected 0010", m_ack); else n_pass++;
        step();
        m_req = '0;
        s_ack = '0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_fixed_priority();
        test_concurrency();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout got running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
